// File: rtl/acl2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acl2_pkg
// Description : Shared constants for the PMOD ACL2 (ADXL362) transaction
//               sequencer: SPI instruction bytes, register addresses, step
//               limits and the sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package acl2_pkg;

    // ADXL362 SPI instruction bytes
    localparam logic [7:0] INSTR_WRITE = 8'h0A;
    localparam logic [7:0] INSTR_READ  = 8'h0B;

    // Data registers, read in this order (XL, XH, YL, YH, ZL, ZH)
    localparam logic [7:0] ADDR_XDATA_L = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H = 8'h13;

    // Configuration registers
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    // Last step index of each phase
    localparam logic [2:0] CFG_LAST_STEP = 3'd1;
    localparam logic [2:0] RD_LAST_STEP  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_WAIT_TMR = 3'd3,
        ST_PUBLISH  = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    // Data registers are contiguous, so read step n maps to XDATA_L + n.
    function automatic logic [7:0] read_addr(input logic [2:0] idx);
        return ADDR_XDATA_L + {5'd0, idx};
    endfunction

endpackage : acl2_pkg
`default_nettype wire

// File: rtl/acl2_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : acl2_ctrl_if
// Description : Command/response bus between the ACL2 sequencer and the
//               SPI master.
// Signals     : spi_load  - one-cycle transaction start pulse
//               spi_instr - instruction byte (0x0A write / 0x0B read)
//               spi_addr  - register address
//               spi_wdata - write byte (0x00 on reads)
//               spi_rdata - read byte, valid with spi_done
//               spi_done  - one-cycle transaction-complete pulse
// Modports    : master (sequencer side), slave (SPI master side)
// Revision    : 1.0 - initial release
// ============================================================================
interface acl2_ctrl_if;

    logic       spi_load;
    logic [7:0] spi_instr;
    logic [7:0] spi_addr;
    logic [7:0] spi_wdata;
    logic [7:0] spi_rdata;
    logic       spi_done;

    modport master (
        output spi_load,
        output spi_instr,
        output spi_addr,
        output spi_wdata,
        input  spi_rdata,
        input  spi_done
    );

    modport slave (
        input  spi_load,
        input  spi_instr,
        input  spi_addr,
        input  spi_wdata,
        output spi_rdata,
        output spi_done
    );

endinterface : acl2_ctrl_if
`default_nettype wire

// File: rtl/acl2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acl2_ctrl
// Description : Transaction sequencer upstream of the PMOD ACL2 SPI master.
//               After reset it writes FILTER_CTL and POWER_CTL, then
//               periodically reads the six X/Y/Z data registers and
//               publishes three 12-bit samples with a one-cycle valid pulse.
// Ports       : clk          - system clock
//               rstn         - asynchronous active-low reset
//               enable       - run sequencer; low parks in IDLE
//               spi          - command/response bus (master modport)
//               x/y/z_data   - 12-bit signed samples
//               sample_valid - one-cycle pulse when samples update
//               cfg_done     - sticky, configuration writes complete
//               err          - sticky, transaction timeout
// Revision    : 1.0 - initial release
// ============================================================================
module acl2_ctrl
    import acl2_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [7:0]  FILTER_VAL = 8'h13,
    parameter logic [7:0]  POWER_VAL  = 8'h02
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        enable,
    acl2_ctrl_if.master      spi,
    output      logic [11:0] x_data,
    output      logic [11:0] y_data,
    output      logic [11:0] z_data,
    output      logic        sample_valid,
    output      logic        cfg_done,
    output      logic        err
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0] c_div_load = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [DIV_W-1:0] r_div;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_shadow [0:5];

    logic             w_last_step;
    logic [2:0]       w_next_idx;

    // cfg_done doubles as the phase flag: low = config steps, high = reads.
    assign w_last_step = cfg_done ? (r_idx == RD_LAST_STEP) : (r_idx == CFG_LAST_STEP);
    assign w_next_idx  = r_idx + 3'd1;

    // {instr, addr, wdata} for a given step of the current phase.
    function automatic logic [23:0] step_cmd(input logic rd_phase, input logic [2:0] idx);
        if (rd_phase) begin
            return {INSTR_READ, read_addr(idx), 8'h00};
        end else if (idx == 3'd0) begin
            return {INSTR_WRITE, ADDR_FILTER_CTL, FILTER_VAL};
        end else begin
            return {INSTR_WRITE, ADDR_POWER_CTL, POWER_VAL};
        end
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_div         <= '0;
            r_tmo         <= '0;
            for (int i = 0; i < 6; i++) begin
                r_shadow[i] <= 8'h00;
            end
            spi.spi_load  <= 1'b0;
            spi.spi_instr <= 8'h00;
            spi.spi_addr  <= 8'h00;
            spi.spi_wdata <= 8'h00;
            x_data        <= 12'h000;
            y_data        <= 12'h000;
            z_data        <= 12'h000;
            sample_valid  <= 1'b0;
            cfg_done      <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Both pulses are high only in the cycle after they are set.
            spi.spi_load <= 1'b0;
            sample_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        if (!cfg_done) begin
                            r_idx        <= 3'd0;
                            {spi.spi_instr, spi.spi_addr, spi.spi_wdata} <= step_cmd(1'b0, 3'd0);
                            spi.spi_load <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_div   <= c_div_load;
                            r_state <= ST_WAIT_TMR;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // spi_done is checked first so it wins a tie with expiry.
                    if (spi.spi_done) begin
                        if (cfg_done) begin
                            r_shadow[r_idx] <= spi.spi_rdata;
                        end else if (r_idx == CFG_LAST_STEP) begin
                            cfg_done <= 1'b1;
                        end

                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else if (w_last_step) begin
                            if (cfg_done) begin
                                // ZH arrives this cycle, so take it straight from the bus.
                                x_data       <= {r_shadow[1][3:0], r_shadow[0]};
                                y_data       <= {r_shadow[3][3:0], r_shadow[2]};
                                z_data       <= {spi.spi_rdata[3:0], r_shadow[4]};
                                sample_valid <= 1'b1;
                                r_state      <= ST_PUBLISH;
                            end else begin
                                r_div   <= c_div_load;
                                r_state <= ST_WAIT_TMR;
                            end
                        end else begin
                            r_idx        <= w_next_idx;
                            {spi.spi_instr, spi.spi_addr, spi.spi_wdata} <= step_cmd(cfg_done, w_next_idx);
                            spi.spi_load <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        err     <= 1'b1;
                        r_state <= ST_ERROR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_WAIT_TMR: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (r_div == '0) begin
                        r_idx        <= 3'd0;
                        {spi.spi_instr, spi.spi_addr, spi.spi_wdata} <= step_cmd(1'b1, 3'd0);
                        spi.spi_load <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end

                ST_PUBLISH: begin
                    r_div   <= c_div_load;
                    r_state <= ST_WAIT_TMR;
                end

                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : acl2_ctrl
`default_nettype wire

// File: tb/tb_acl2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acl2_ctrl
// Description : Directed self-checking bench for acl2_ctrl with a simple
//               SPI-master response model (configurable response latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acl2_ctrl;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [11:0] x_data, y_data, z_data;
    logic        sample_valid, cfg_done, err;

    acl2_ctrl_if bus ();

    acl2_ctrl #(
        .SAMPLE_DIV (4),
        .TIMEOUT    (16),
        .FILTER_VAL (8'h13),
        .POWER_VAL  (8'h02)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .spi          (bus.master),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
        .sample_valid (sample_valid),
        .cfg_done     (cfg_done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- SPI master response model ----------------
    int         resp_delay = 2;
    bit         no_resp    = 0;
    logic [7:0] rd_bytes [0:5];
    int         rd_idx     = 0;
    bit         pending    = 0;
    int         wcnt       = 0;
    logic [7:0] cur_instr  = 8'h00;
    bit         prev_load  = 0;
    bit         consec     = 0;
    int         n_loads    = 0;
    int         sv_count   = 0;
    logic [7:0] log_instr [0:255];
    logic [7:0] log_addr  [0:255];
    logic [7:0] log_wdata [0:255];

    initial begin
        bus.spi_done  = 1'b0;
        bus.spi_rdata = 8'h00;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            pending      = 0;
            wcnt         = 0;
            prev_load    = 0;
            bus.spi_done = 1'b0;
        end else begin
            bus.spi_done = 1'b0;
            if (sample_valid) sv_count++;
            if (pending) begin
                wcnt++;
                if (!no_resp && wcnt == resp_delay) begin
                    bus.spi_done = 1'b1;
                    pending      = 0;
                    if (cur_instr == 8'h0B) begin
                        bus.spi_rdata = rd_bytes[rd_idx];
                        rd_idx++;
                    end else begin
                        bus.spi_rdata = 8'hEE;
                    end
                end
            end
            if (bus.spi_load) begin
                if (prev_load) consec = 1;
                if (n_loads < 256) begin
                    log_instr[n_loads] = bus.spi_instr;
                    log_addr[n_loads]  = bus.spi_addr;
                    log_wdata[n_loads] = bus.spi_wdata;
                end
                n_loads++;
                if (bus.spi_addr == 8'h0E) rd_idx = 0;
                cur_instr = bus.spi_instr;
                pending   = 1;
                wcnt      = 0;
            end
            prev_load = bus.spi_load;
        end
    end

    // Sample point: 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sample_valid) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: sample_valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_cfg(input int budget, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cfg_done) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: cfg_done=%b after %0d cycles, required 1", name, cfg_done, budget);
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({bus.spi_load, bus.spi_instr, bus.spi_addr, bus.spi_wdata} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: load=%b instr=%h addr=%h wdata=%h, required all 0",
                     bus.spi_load, bus.spi_instr, bus.spi_addr, bus.spi_wdata);
        end
        tests_run++;
        if ({x_data, y_data, z_data, sample_valid, cfg_done, err} !== 39'd0) begin
            tests_failed++;
            $display("FAIL reset_out: x=%h y=%h z=%h sv=%b cfg=%b err=%b, required all 0",
                     x_data, y_data, z_data, sample_valid, cfg_done, err);
        end
    endtask

    task automatic test_config();
        rd_bytes[0] = 8'h34; rd_bytes[1] = 8'hF8; rd_bytes[2] = 8'hFF;
        rd_bytes[3] = 8'h07; rd_bytes[4] = 8'h00; rd_bytes[5] = 8'h00;
        enable = 1'b1;
        rstn   = 1'b1;
        wait_cfg(100, "config_wait");
        tests_run++;
        if (n_loads !== 2) begin
            tests_failed++;
            $display("FAIL config_count: loads=%0d required 2", n_loads);
        end
        tests_run++;
        if ({log_instr[0], log_addr[0], log_wdata[0]} !== 24'h0A2C13) begin
            tests_failed++;
            $display("FAIL config_step0: got %h%h%h required 0a2c13", log_instr[0], log_addr[0], log_wdata[0]);
        end
        tests_run++;
        if ({log_instr[1], log_addr[1], log_wdata[1]} !== 24'h0A2D02) begin
            tests_failed++;
            $display("FAIL config_step1: got %h%h%h required 0a2d02", log_instr[1], log_addr[1], log_wdata[1]);
        end
    endtask

    task automatic test_sample();
        logic [7:0] exp_addr;
        wait_valid(200, "sample_wait");
        tests_run++;
        if ({x_data, y_data, z_data} !== {12'h834, 12'h7FF, 12'h000}) begin
            tests_failed++;
            $display("FAIL sample_values: x=%h y=%h z=%h required 834 7ff 000", x_data, y_data, z_data);
        end
        for (int i = 0; i < 6; i++) begin
            exp_addr = 8'h0E + 8'(i);
            tests_run++;
            if ({log_instr[2+i], log_addr[2+i], log_wdata[2+i]} !== {8'h0B, exp_addr, 8'h00}) begin
                tests_failed++;
                $display("FAIL sample_read%0d: got %h%h%h required 0b%h00", i,
                         log_instr[2+i], log_addr[2+i], log_wdata[2+i], exp_addr);
            end
        end
        enable = 1'b0;
        tick();
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sample_pulse_width: sample_valid=%b required 0", sample_valid);
        end
        repeat (20) tick();
        tests_run++;
        if (sv_count !== 1 || n_loads !== 8 || x_data !== 12'h834) begin
            tests_failed++;
            $display("FAIL sample_park: pulses=%0d loads=%0d x=%h required 1 8 834", sv_count, n_loads, x_data);
        end
    endtask

    task automatic test_enable_drop();
        int  nl, sv, k;
        bit  seen;
        rd_bytes[0] = 8'h21; rd_bytes[1] = 8'h43; rd_bytes[2] = 8'h65;
        rd_bytes[3] = 8'h87; rd_bytes[4] = 8'hA9; rd_bytes[5] = 8'hFC;
        enable = 1'b1;
        seen   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.spi_load && bus.spi_addr == 8'h11) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL drop_step3: read of 0x11 not seen");
        end
        enable = 1'b0;
        nl = n_loads;
        sv = sv_count;
        repeat (20) tick();
        tests_run++;
        if (n_loads !== nl || sv_count !== sv || x_data !== 12'h834) begin
            tests_failed++;
            $display("FAIL drop_idle: loads=%0d pulses=%0d x=%h required %0d %0d 834",
                     n_loads, sv_count, x_data, nl, sv);
        end
        enable = 1'b1;
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (n_loads > nl) begin
                k = i;
                break;
            end
        end
        tests_run++;
        if (k !== 5 || log_instr[nl] !== 8'h0B || log_addr[nl] !== 8'h0E) begin
            tests_failed++;
            $display("FAIL drop_resume: delay=%0d instr=%h addr=%h required 5 0b 0e", k, log_instr[nl], log_addr[nl]);
        end
        wait_valid(200, "drop_burst_wait");
        tests_run++;
        if ({x_data, y_data, z_data} !== {12'h321, 12'h765, 12'hCA9}) begin
            tests_failed++;
            $display("FAIL drop_burst: x=%h y=%h z=%h required 321 765 ca9", x_data, y_data, z_data);
        end
        enable = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_tie();
        rd_bytes[0] = 8'h00; rd_bytes[1] = 8'h08; rd_bytes[2] = 8'hFF;
        rd_bytes[3] = 8'h0F; rd_bytes[4] = 8'h80; rd_bytes[5] = 8'h00;
        resp_delay = 16;
        enable     = 1'b1;
        wait_valid(400, "tie_wait");
        tests_run++;
        if (err !== 1'b0 || {x_data, y_data, z_data} !== {12'h800, 12'hFFF, 12'h080}) begin
            tests_failed++;
            $display("FAIL tie: err=%b x=%h y=%h z=%h required 0 800 fff 080", err, x_data, y_data, z_data);
        end
        enable = 1'b0;
        repeat (10) tick();
        resp_delay = 2;
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  seen;
        enable = 1'b1;
        seen   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.spi_load && bus.spi_addr == 8'h10) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL rstmid_step2: read of 0x10 not seen");
        end
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({bus.spi_load, bus.spi_instr, bus.spi_addr, bus.spi_wdata, x_data, y_data, z_data,
             sample_valid, cfg_done, err} !== 64'd0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: load=%b instr=%h addr=%h x=%h y=%h z=%h cfg=%b err=%b, required all 0",
                     bus.spi_load, bus.spi_instr, bus.spi_addr, x_data, y_data, z_data, cfg_done, err);
        end
        repeat (2) tick();
        base = n_loads;
        rstn = 1'b1;
        wait_cfg(100, "rstmid_cfg_wait");
        tests_run++;
        if ({log_instr[base], log_addr[base], log_wdata[base],
             log_instr[base+1], log_addr[base+1], log_wdata[base+1]} !== 48'h0A2C13_0A2D02) begin
            tests_failed++;
            $display("FAIL rstmid_reconfig: got %h%h%h %h%h%h required 0a2c13 0a2d02",
                     log_instr[base], log_addr[base], log_wdata[base],
                     log_instr[base+1], log_addr[base+1], log_wdata[base+1]);
        end
    endtask

    task automatic test_timeout();
        int  nl;
        bit  seen;
        no_resp = 1;
        seen    = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pending && wcnt == 16) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (!seen || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_cycle16: reached=%b err=%b required 1 0", seen, err);
        end
        tick();
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_err: err=%b required 1", err);
        end
        nl = n_loads;
        repeat (30) tick();
        tests_run++;
        if (n_loads !== nl || bus.spi_load !== 1'b0 || err !== 1'b1 || x_data !== 12'h000) begin
            tests_failed++;
            $display("FAIL timeout_terminal: loads=%0d load=%b err=%b x=%h required %0d 0 1 000",
                     n_loads, bus.spi_load, err, x_data, nl);
        end
    endtask

    task automatic test_load_spacing();
        tests_run++;
        if (consec !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_spacing: back-to-back spi_load seen=%b required 0", consec);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_sample();
        test_enable_drop();
        test_tie();
        test_reset_mid();
        test_timeout();
        test_load_spacing();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_acl2_ctrl
`default_nettype wire
